// File: rtl/bp_fe_btb_assoc.sv
// Set-associative branch target buffer with tree pseudo-LRU replacement and a hashed index.
// A read returns the hit way or the replacement victim so the writer can fill that exact way.
module bp_fe_btb_assoc
  #(parameter int vaddr_width_p   = 39
  , parameter int btb_tag_width_p = 10
  , parameter int btb_idx_width_p = 6
  , parameter int btb_assoc_p     = 2
  , parameter int hash_base_p     = 1
  , parameter int hash_width_p    = 1
  , localparam int way_w_lp  = (btb_assoc_p > 1) ? $clog2(btb_assoc_p) : 1
  , localparam int plru_w_lp = (btb_assoc_p > 1) ? btb_assoc_p - 1 : 1
  , localparam int sets_lp   = 1 << btb_idx_width_p
  )
  (input  logic                       clk_i
  , input  logic                       reset_i
  , output logic                       init_done_o
  , input  logic                       r_v_i
  , input  logic [vaddr_width_p-1:0]   r_addr_i
  , output logic [btb_tag_width_p-1:0] r_tag_o
  , output logic [btb_idx_width_p-1:0] r_idx_o
  , output logic [way_w_lp-1:0]        r_way_o
  , output logic [vaddr_width_p-1:0]   r_tgt_o
  , output logic                       r_tgt_v_o
  , output logic                       r_tgt_jmp_o
  , input  logic                       w_v_i
  , input  logic                       w_force_i
  , input  logic                       w_clr_i
  , input  logic                       w_jmp_i
  , input  logic [btb_tag_width_p-1:0] w_tag_i
  , input  logic [btb_idx_width_p-1:0] w_idx_i
  , input  logic [way_w_lp-1:0]        w_way_i
  , input  logic [vaddr_width_p-1:0]   w_tgt_i
  , output logic                       w_yumi_o
  );

  typedef enum logic [1:0] {e_reset, e_clear, e_run} state_e;

  typedef struct packed {
    logic                       v;
    logic                       jmp;
    logic [btb_tag_width_p-1:0] tag;
    logic [vaddr_width_p-1:0]   tgt;
  } entry_s;

  // Tree bits point toward the victim: 0 selects the lower half, 1 the upper half.
  function automatic logic [way_w_lp-1:0] plru_victim(input logic [plru_w_lp-1:0] bits);
    logic [way_w_lp-1:0]  way;
    logic [plru_w_lp-1:0] sh;
    int n;
    way = '0;
    n   = 0;
    if (btb_assoc_p > 1)
      for (int l = 0; l < way_w_lp; l++) begin
        sh = bits >> n;
        way[way_w_lp-1-l] = sh[0];
        n = 2*n + (sh[0] ? 2 : 1);
      end
    return way;
  endfunction

  function automatic logic [plru_w_lp-1:0] plru_touch(input logic [plru_w_lp-1:0] bits,
                                                      input logic [way_w_lp-1:0]  way);
    logic [plru_w_lp-1:0] res, mask;
    logic b;
    int n;
    res = bits;
    n   = 0;
    if (btb_assoc_p > 1)
      for (int l = 0; l < way_w_lp; l++) begin
        b    = way[way_w_lp-1-l];
        mask = plru_w_lp'(1) << n;
        res  = b ? (res & ~mask) : (res | mask);
        n    = 2*n + (b ? 2 : 1);
      end
    return res;
  endfunction

  state_e                      state_q, state_d;
  logic [btb_idx_width_p-1:0]  init_cnt_q, init_cnt_d;
  logic [plru_w_lp-1:0]        plru_q [sets_lp];
  logic [plru_w_lp-1:0]        plru_d [sets_lp];
  entry_s                      mem_q [sets_lp][btb_assoc_p];

  logic [btb_tag_width_p-1:0]  r_tag_q, r_tag_d;
  logic [btb_idx_width_p-1:0]  r_idx_q, r_idx_d;
  logic [way_w_lp-1:0]         r_way_q, r_way_d;
  logic [vaddr_width_p-1:0]    r_tgt_q, r_tgt_d;
  logic                        r_tgt_v_q, r_tgt_v_d;
  logic                        r_tgt_jmp_q, r_tgt_jmp_d;
  logic                        rd_hit_q, rd_hit_d;

  logic [btb_idx_width_p-1:0]  rd_idx;
  logic [btb_tag_width_p-1:0]  rd_tag;
  logic                        run, rw_same_set, rd_ok, wr_ok;
  logic                        hit, inv_any;
  logic [way_w_lp-1:0]         hit_way, inv_way, victim;
  entry_s                      hit_entry;
  logic [btb_assoc_p-1:0]      mem_we;
  logic [btb_idx_width_p-1:0]  mem_widx;
  entry_s                      mem_wdata;
  logic                        unused_addr;

  assign rd_idx = r_addr_i[2 +: btb_idx_width_p]
                ^ btb_idx_width_p'(r_addr_i[hash_base_p +: hash_width_p]);
  assign rd_tag = r_addr_i[2+btb_idx_width_p +: btb_tag_width_p];
  assign unused_addr = ^r_addr_i;

  assign run         = (state_q == e_run);
  assign rw_same_set = r_v_i & w_v_i & (rd_idx == w_idx_i);
  assign rd_ok       = run & ~(rw_same_set & w_force_i);
  assign wr_ok       = run & w_v_i & ~(rw_same_set & ~w_force_i);
  assign victim      = plru_victim(plru_q[rd_idx]);

  // Descending scan so the lowest-numbered matching or invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_entry = '0;
    inv_any   = 1'b0;
    inv_way   = '0;
    for (int w = btb_assoc_p-1; w >= 0; w--) begin
      if (mem_q[rd_idx][w].v && (mem_q[rd_idx][w].tag == rd_tag)) begin
        hit       = 1'b1;
        hit_way   = way_w_lp'(w);
        hit_entry = mem_q[rd_idx][w];
      end
      if (!mem_q[rd_idx][w].v) begin
        inv_any = 1'b1;
        inv_way = way_w_lp'(w);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      e_reset: state_d = e_clear;
      e_clear: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) state_d = e_run;
      end
      default: state_d = e_run;
    endcase
  end

  always_comb begin
    r_tag_d     = r_tag_q;
    r_idx_d     = r_idx_q;
    r_way_d     = r_way_q;
    r_tgt_d     = r_tgt_q;
    r_tgt_v_d   = r_tgt_v_q;
    r_tgt_jmp_d = r_tgt_jmp_q;
    rd_hit_d    = 1'b0;
    if (r_v_i) begin
      r_tag_d     = rd_tag;
      r_idx_d     = rd_idx;
      r_tgt_v_d   = rd_ok & hit;
      r_tgt_jmp_d = rd_ok & hit & hit_entry.jmp;
      r_tgt_d     = (rd_ok & hit) ? hit_entry.tgt : '0;
      r_way_d     = !rd_ok ? '0 : hit ? hit_way : inv_any ? inv_way : victim;
      rd_hit_d    = rd_ok & hit;
    end
  end

  always_comb begin
    mem_we    = '0;
    mem_widx  = w_idx_i;
    mem_wdata = '0;
    if (state_q == e_clear) begin
      mem_we   = '1;
      mem_widx = init_cnt_q;
    end else if (wr_ok) begin
      for (int w = 0; w < btb_assoc_p; w++)
        mem_we[w] = (w_way_i == way_w_lp'(w));
      if (!w_clr_i)
        mem_wdata = '{v: 1'b1, jmp: w_jmp_i, tag: w_tag_i, tgt: w_tgt_i};
    end
  end

  // The write touch is applied last so it wins when both land on one set.
  always_comb begin
    plru_d = plru_q;
    if (rd_hit_q)
      plru_d[r_idx_q] = plru_touch(plru_q[r_idx_q], r_way_q);
    if (wr_ok && !w_clr_i)
      plru_d[w_idx_i] = plru_touch(plru_q[w_idx_i], w_way_i);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= e_reset;
      init_cnt_q  <= '0;
      r_tag_q     <= '0;
      r_idx_q     <= '0;
      r_way_q     <= '0;
      r_tgt_q     <= '0;
      r_tgt_v_q   <= 1'b0;
      r_tgt_jmp_q <= 1'b0;
      rd_hit_q    <= 1'b0;
      for (int s = 0; s < sets_lp; s++) plru_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      r_tag_q     <= r_tag_d;
      r_idx_q     <= r_idx_d;
      r_way_q     <= r_way_d;
      r_tgt_q     <= r_tgt_d;
      r_tgt_v_q   <= r_tgt_v_d;
      r_tgt_jmp_q <= r_tgt_jmp_d;
      rd_hit_q    <= rd_hit_d;
      plru_q      <= plru_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int w = 0; w < btb_assoc_p; w++)
      if (mem_we[w]) mem_q[mem_widx][w] <= mem_wdata;
  end

  assign init_done_o = run;
  assign w_yumi_o    = wr_ok;
  assign r_tag_o     = r_tag_q;
  assign r_idx_o     = r_idx_q;
  assign r_way_o     = r_way_q;
  assign r_tgt_o     = r_tgt_q;
  assign r_tgt_v_o   = r_tgt_v_q;
  assign r_tgt_jmp_o = r_tgt_jmp_q;

endmodule

// File: tb/tb_bp_fe_btb_assoc.sv
// Directed bench for the 2-way BTB: a reference table and PLRU bit per set predict each
// read response, which is queued at drive time and popped when the registered result appears.
module tb_bp_fe_btb_assoc;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        init_done_o;
  logic        r_v_i;
  logic [38:0] r_addr_i;
  logic [9:0]  r_tag_o;
  logic [5:0]  r_idx_o;
  logic [0:0]  r_way_o;
  logic [38:0] r_tgt_o;
  logic        r_tgt_v_o;
  logic        r_tgt_jmp_o;
  logic        w_v_i;
  logic        w_force_i;
  logic        w_clr_i;
  logic        w_jmp_i;
  logic [9:0]  w_tag_i;
  logic [5:0]  w_idx_i;
  logic [0:0]  w_way_i;
  logic [38:0] w_tgt_i;
  logic        w_yumi_o;

  always #5 clk_i = ~clk_i;

  bp_fe_btb_assoc #(
    .vaddr_width_p(39), .btb_tag_width_p(10), .btb_idx_width_p(6),
    .btb_assoc_p(2), .hash_base_p(1), .hash_width_p(1)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .init_done_o(init_done_o),
    .r_v_i(r_v_i), .r_addr_i(r_addr_i), .r_tag_o(r_tag_o), .r_idx_o(r_idx_o),
    .r_way_o(r_way_o), .r_tgt_o(r_tgt_o), .r_tgt_v_o(r_tgt_v_o), .r_tgt_jmp_o(r_tgt_jmp_o),
    .w_v_i(w_v_i), .w_force_i(w_force_i), .w_clr_i(w_clr_i), .w_jmp_i(w_jmp_i),
    .w_tag_i(w_tag_i), .w_idx_i(w_idx_i), .w_way_i(w_way_i), .w_tgt_i(w_tgt_i),
    .w_yumi_o(w_yumi_o)
  );

  typedef struct {
    logic        v;
    logic        jmp;
    logic [38:0] tgt;
    logic        way;
    logic [9:0]  tag;
    logic [5:0]  idx;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  logic        m_v   [64][2];
  logic        m_jmp [64][2];
  logic [9:0]  m_tag [64][2];
  logic [38:0] m_tgt [64][2];
  logic        m_plru[64];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Upper bits are filler the index/tag extraction must ignore.
  function automatic logic [38:0] pc_of(input logic [5:0] idx, input logic [9:0] tag,
                                        input logic hbit);
    logic [5:0] raw;
    raw = idx ^ {5'b0, hbit};
    return {21'h0A5A5, tag, raw, hbit, 1'b0};
  endfunction

  task automatic modelReset();
    for (int s = 0; s < 64; s++) begin
      m_plru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_v[s][w] = 1'b0; m_jmp[s][w] = 1'b0; m_tag[s][w] = '0; m_tgt[s][w] = '0;
      end
    end
    sb.delete();
    last_exp.v = 0; last_exp.jmp = 0; last_exp.tgt = '0;
    last_exp.way = 0; last_exp.tag = '0; last_exp.idx = '0;
    cyc = 0;
  endtask

  task automatic setRead(input logic [5:0] idx, input logic [9:0] tag, input logic hbit);
    r_v_i = 1'b1;
    r_addr_i = pc_of(idx, tag, hbit);
  endtask

  task automatic setWrite(input logic [5:0] idx, input logic way, input logic [9:0] tag,
                          input logic [38:0] tgt, input logic jmp, input logic clr,
                          input logic force_w);
    w_v_i = 1'b1; w_idx_i = idx; w_way_i = way; w_tag_i = tag;
    w_tgt_i = tgt; w_jmp_i = jmp; w_clr_i = clr; w_force_i = force_w;
  endtask

  // One clock of stimulus: predicts acceptance and the read response, then advances.
  task automatic applyStimulus();
    logic [5:0] ridx;
    logic [9:0] rtag;
    logic run, conflict, rd_ok, wr_ok, hit, hway;
    exp_t e;
    run      = (cyc >= 65);
    ridx     = r_addr_i[7:2] ^ {5'b0, r_addr_i[1]};
    rtag     = r_addr_i[17:8];
    conflict = r_v_i && w_v_i && (ridx == w_idx_i);
    rd_ok    = run && !(conflict && w_force_i);
    wr_ok    = run && w_v_i && !(conflict && !w_force_i);
    #1;
    if (w_v_i) chk("w_yumi", 64'(w_yumi_o), 64'(wr_ok));
    if (r_v_i) begin
      hit = 1'b0; hway = 1'b0;
      for (int w = 1; w >= 0; w--)
        if (m_v[ridx][w] && m_tag[ridx][w] == rtag) begin hit = 1'b1; hway = w[0]; end
      e.tag = rtag; e.idx = ridx;
      e.v   = rd_ok && hit;
      e.jmp = e.v && m_jmp[ridx][hway];
      e.tgt = e.v ? m_tgt[ridx][hway] : '0;
      if (!rd_ok)              e.way = 1'b0;
      else if (hit)            e.way = hway;
      else if (!m_v[ridx][0])  e.way = 1'b0;
      else if (!m_v[ridx][1])  e.way = 1'b1;
      else                     e.way = m_plru[ridx];
      sb.push_back(e);
      if (e.v) m_plru[ridx] = ~hway;
    end
    if (wr_ok) begin
      m_v  [w_idx_i][w_way_i] = !w_clr_i;
      m_jmp[w_idx_i][w_way_i] = w_clr_i ? 1'b0 : w_jmp_i;
      m_tag[w_idx_i][w_way_i] = w_clr_i ? '0 : w_tag_i;
      m_tgt[w_idx_i][w_way_i] = w_clr_i ? '0 : w_tgt_i;
      if (!w_clr_i) m_plru[w_idx_i] = ~w_way_i[0];
    end
    @(negedge clk_i);
    r_v_i = 1'b0; w_v_i = 1'b0; w_force_i = 1'b0; w_clr_i = 1'b0;
    cyc++;
    chk("init_done", 64'(init_done_o), 64'(cyc >= 65));
  endtask

  task automatic checkOutput(input bit hold);
    exp_t e;
    if (hold) e = last_exp;
    else begin
      checks++;
      assert (sb.size() != 0) passes++;
      else $error("[TB] FAIL scoreboard: got %0d entries expected 1", sb.size());
      if (sb.size() == 0) return;
      e = sb.pop_front();
      last_exp = e;
    end
    chk("r_tgt_v", 64'(r_tgt_v_o), 64'(e.v));
    chk("r_tgt_jmp", 64'(r_tgt_jmp_o), 64'(e.jmp));
    chk("r_way", 64'(r_way_o), 64'(e.way));
    chk("r_tag", 64'(r_tag_o), 64'(e.tag));
    chk("r_idx", 64'(r_idx_o), 64'(e.idx));
    if (e.v) chk("r_tgt", 64'(r_tgt_o), 64'(e.tgt));
  endtask

  // Asserts reset between edges and expects every output to clear at once.
  task automatic pulseReset();
    #2 reset_i = 1'b1;
    #1;
    chk("rst_init_done", 64'(init_done_o), 64'd0);
    chk("rst_w_yumi", 64'(w_yumi_o), 64'd0);
    chk("rst_r_tgt_v", 64'(r_tgt_v_o), 64'd0);
    chk("rst_r_tgt_jmp", 64'(r_tgt_jmp_o), 64'd0);
    chk("rst_r_tag", 64'(r_tag_o), 64'd0);
    chk("rst_r_idx", 64'(r_idx_o), 64'd0);
    chk("rst_r_way", 64'(r_way_o), 64'd0);
    modelReset();
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0; r_v_i = 0; r_addr_i = '0; w_v_i = 0; w_force_i = 0; w_clr_i = 0;
    w_jmp_i = 0; w_tag_i = '0; w_idx_i = '0; w_way_i = '0; w_tgt_i = '0;
    pulseReset();

    for (int i = 0; i < 10; i++) applyStimulus();
    setRead(6'd3, 10'h2C5, 1'b0); applyStimulus(); checkOutput(0);
    while (cyc < 65) applyStimulus();

    $display("[TB] table ready, directed reads and writes");
    setRead(6'd7, 10'h011, 1'b0); applyStimulus(); checkOutput(0);

    setWrite(6'd5, 1'b0, 10'h03A, 39'h0_8000_1000, 1'b1, 1'b0, 1'b0); applyStimulus();
    setRead(6'd5, 10'h03A, 1'b1); applyStimulus(); checkOutput(0);
    applyStimulus(); checkOutput(1);

    setWrite(6'd5, 1'b1, 10'h02B, 39'h12_3456_7898, 1'b0, 1'b0, 1'b0); applyStimulus();
    setRead(6'd5, 10'h03A, 1'b0); applyStimulus(); checkOutput(0); applyStimulus();
    setRead(6'd5, 10'h155, 1'b1); applyStimulus(); checkOutput(0);
    setRead(6'd5, 10'h02B, 1'b0); applyStimulus(); checkOutput(0); applyStimulus();
    setRead(6'd5, 10'h0C3, 1'b0); applyStimulus(); checkOutput(0);

    setWrite(6'd9, 1'b0, 10'h101, 39'h00_0000_4440, 1'b0, 1'b0, 1'b0); applyStimulus();
    setRead(6'd9, 10'h101, 1'b0);
    setWrite(6'd9, 1'b1, 10'h0F5, 39'h7F_FFFF_FFFC, 1'b1, 1'b0, 1'b0);
    applyStimulus(); checkOutput(0); applyStimulus();
    setRead(6'd9, 10'h101, 1'b1);
    setWrite(6'd9, 1'b1, 10'h0F5, 39'h7F_FFFF_FFFC, 1'b1, 1'b0, 1'b1);
    applyStimulus(); checkOutput(0);
    setRead(6'd9, 10'h0F5, 1'b0); applyStimulus(); checkOutput(0); applyStimulus();

    setRead(6'd9, 10'h101, 1'b0);
    setWrite(6'd10, 1'b0, 10'h222, 39'h00_0000_1000, 1'b0, 1'b0, 1'b0);
    applyStimulus(); checkOutput(0); applyStimulus();
    setRead(6'd10, 10'h222, 1'b1); applyStimulus(); checkOutput(0); applyStimulus();

    setRead(6'd5, 10'h03A, 1'b0); applyStimulus(); checkOutput(0); applyStimulus();
    setWrite(6'd5, 1'b0, 10'h03A, 39'h0, 1'b0, 1'b1, 1'b0); applyStimulus();
    setRead(6'd5, 10'h03A, 1'b0); applyStimulus(); checkOutput(0);
    setRead(6'd5, 10'h02B, 1'b0); applyStimulus(); checkOutput(0); applyStimulus();

    $display("[TB] reset during run and mid-clear");
    pulseReset();
    for (int i = 0; i < 20; i++) applyStimulus();
    setRead(6'd12, 10'h3FF, 1'b1); applyStimulus(); checkOutput(0);
    while (cyc < 30) applyStimulus();
    pulseReset();
    while (cyc < 65) applyStimulus();
    setRead(6'd9, 10'h101, 1'b0); applyStimulus(); checkOutput(0);
    setRead(6'd5, 10'h02B, 1'b1); applyStimulus(); checkOutput(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bp_fe_btb_assoc.md
Name: bp_fe_btb_assoc

Overview:
Set-associative branch target buffer for the FE. Generalises the direct-mapped BTB to btb_assoc_p ways per set with tree pseudo-LRU replacement and a hashed index. It sits between the PC-gen read path (predict on fetch PC) and the redirect/commit write path. On a read it returns the hit way, or the replacement victim, so the writer can update exactly that way with a single-cycle write.

Parameters:
vaddr_width_p, 39, virtual address width
btb_tag_width_p, 10, stored tag width
btb_idx_width_p, 6, set index width; sets = 2^btb_idx_width_p
btb_assoc_p, 2, ways per set; power of two, 1..8; 1 degenerates to direct-mapped with no LRU state
hash_base_p, 1, low bit of r_addr_i XORed into the index
hash_width_p, 1, number of hash bits, at most btb_idx_width_p

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
init_done_o  out  1  set clear complete; the table is usable
r_v_i  in  1  read request
r_addr_i  in  vaddr_width_p  fetch PC
r_tag_o  out  btb_tag_width_p  registered tag of the last accepted read
r_idx_o  out  btb_idx_width_p  registered hashed index of the last accepted read
r_way_o  out  clog2(btb_assoc_p), min 1  hit way, or victim way on a miss
r_tgt_o  out  vaddr_width_p  target from the hit way
r_tgt_v_o  out  1  hit
r_tgt_jmp_o  out  1  hit entry is an unconditional jump
w_v_i  in  1  write request
w_force_i  in  1  write wins an index conflict with a same-cycle read
w_clr_i  in  1  invalidate the addressed way instead of filling it
w_jmp_i  in  1  jump flag to store
w_tag_i  in  btb_tag_width_p  tag to store
w_idx_i  in  btb_idx_width_p  set to write
w_way_i  in  clog2(btb_assoc_p)  way to write
w_tgt_i  in  vaddr_width_p  target to store
w_yumi_o  out  1  write accepted this cycle

Behaviour:
- Reset is asynchronous and active-high. It clears the FSM to e_reset, the init counter to 0, all PLRU bits to 0 and all output registers. init_done_o, w_yumi_o, r_tgt_v_o and r_tgt_jmp_o reset to 0; r_tag_o, r_idx_o and r_way_o reset to 0.
- Reset asserted mid-clear or mid-run: state is lost, and the full clear re-runs after deassertion.
- FSM:
  - e_reset always moves to e_clear.
  - e_clear writes all ways of set init_cnt to zero (v=0) and increments init_cnt; it moves to e_run after set 2^idx-1.
  - Total time to init_done_o=1 is 2^btb_idx_width_p+1 cycles after reset deasserts.
  - e_run is terminal.
- Index and tag:
  - idx = r_addr_i[2 +: idx] XOR zero-extended r_addr_i[hash_base_p +: hash_width_p].
  - tag = r_addr_i[2+idx +: tag].
- Reads:
  - Results appear 1 cycle after r_v_i.
  - r_tag_o and r_idx_o load whenever r_v_i=1; otherwise they hold.
  - A read is valid if r_v_i=1, the FSM is in e_run and the read is not suppressed. A suppressed or non-run read yields r_tgt_v_o=0 the next cycle.
  - When r_v_i=0, the outputs hold their previous values (latch-last-read).
- Hit:
  - Hit means any way has v=1 and a stored tag equal to r_tag_o.
  - If several ways match, the lowest-numbered way wins.
  - r_tgt_v_o=1; r_tgt_o and r_tgt_jmp_o come from the winning way; r_way_o is that way.
- Miss:
  - r_tgt_v_o=0 and r_tgt_jmp_o=0; r_tgt_o is don't-care.
  - r_way_o is the lowest invalid way if one exists; otherwise it is the PLRU victim of the set.
- PLRU:
  - One tree of btb_assoc_p-1 bits per set, held in flops.
  - Updated in the response cycle of a valid hit read, to point away from the hit way.
  - Updated on an accepted non-clear write, to point away from w_way_i.
  - If both updates target the same set in one cycle, the write update applies.
- Write conflict: rw_same_set = r_v_i & w_v_i & (read idx == w_idx_i).
  - With w_force_i=1, the write proceeds and the read is suppressed.
  - With w_force_i=0, the write is suppressed: w_yumi_o=0 and the writer holds its request.
- Writes:
  - Accepted when the FSM is in e_run, w_v_i=1 and the write is not suppressed; w_yumi_o=1 in that same cycle.
  - During e_clear, w_yumi_o=0.
  - An accepted write stores {v=1, jmp, tag, tgt} to (w_idx_i, w_way_i). With w_clr_i=1 it stores all zeros and leaves the PLRU unchanged.
  - Writes to other sets never disturb reads in flight.

Test Plan:
- Reset, then idle: init_done_o=0 for 65 cycles (idx=6) and rises on cycle 65. A read of any PC before or just after init -> r_tgt_v_o=0, r_way_o=0.
- Write (idx=5, way=0, tag=0x3A, tgt=0x8000_1000, jmp=1), then read a PC mapping to idx 5 with tag 0x3A -> next cycle r_tgt_v_o=1, r_tgt_o=0x8000_1000, r_tgt_jmp_o=1, r_way_o=0.
- Fill ways 0 and 1 of set 5 (2-way), then hit way 0 -> the next miss to set 5 reports r_way_o=1. Then hit way 1 -> the next miss reports r_way_o=0.
- Same-cycle read and write to set 9: with w_force_i=0 -> w_yumi_o=0 and the read returns data. With w_force_i=1 -> w_yumi_o=1 and the read returns r_tgt_v_o=0.
- Write with w_clr_i=1 to a valid way -> a subsequent read of that tag misses, and r_way_o is the cleared way as the lowest invalid way.
- Assert reset_i asynchronously mid-clear (init_cnt=30) -> all outputs 0 immediately; the clear restarts and init_done_o rises 65 cycles after deassertion.
